// File: rtl/alu_pkg.sv
// alu_pkg: alu opcodes and sequencer state encoding shared by the alu and its controller
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_LT  = 4'b0110;
  typedef enum logic [2:0] {IDLE, M_ADD, M_DEC, D_CMP, D_SUB, D_INC, DONE} state_e;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: start/busy/done request bus and result outputs of the sequencer
interface alu_seq_ctrl_if #(parameter int N = 4);
  logic         start;
  logic         mode;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         busy;
  logic         done;
  logic [N-1:0] res;
  logic [N-1:0] rem;
  logic         ovf;
  logic         err;
  modport master (output start, mode, op_a, op_b, input busy, done, res, rem, ovf, err);
  modport slave (input start, mode, op_a, op_b, output busy, done, res, rem, ovf, err);
endinterface

// File: rtl/alu.sv
// alu: combinational add/sub/less-than unit shared with the sequencer
module alu
  import alu_pkg::*;
#(parameter int N = 4) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   op_i,
  output logic [N-1:0] o_o,
  output logic         of_o,
  output logic         zero_o
);
  logic [N:0] sum, dif;
  logic       lt;
  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign dif = {1'b0, a_i} - {1'b0, b_i};
  assign lt  = a_i < b_i;
  // result select; on LT the zero flag carries the compare outcome
  always_comb begin
    o_o    = op_i == ALU_SUB ? dif[N-1:0] : op_i == ALU_LT ? N'(lt) : sum[N-1:0];
    of_o   = op_i == ALU_SUB ? dif[N] : op_i == ALU_ADD ? sum[N] : 1'b0;
    zero_o = op_i == ALU_LT ? lt : o_o == '0;
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle multiply/divide sequencer driving a shared alu
module alu_seq_ctrl
  import alu_pkg::*;
#(parameter int N = 4) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.slave bus,
  output logic [N-1:0]  alu_a_o,
  output logic [N-1:0]  alu_b_o,
  output logic [3:0]    alu_op_o,
  input  logic [N-1:0]  alu_o_i,
  input  logic          alu_of_i,
  input  logic          alu_zero_i
);
  state_e       state_q, state_d;
  logic [N-1:0] res_q, res_d, rem_q, rem_d, cnt_q, cnt_d, opa_q, opa_d, div_q, div_d;
  logic         ovf_q, ovf_d, err_q, err_d;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.res  = res_q;
  assign bus.rem  = rem_q;
  assign bus.ovf  = ovf_q;
  assign bus.err  = err_q;
  // register update; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      div_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end
  // per-state alu drive and next-state; every arithmetic step goes through the alu
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    div_d    = div_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = ALU_ADD;
    case (state_q)
      IDLE: if (bus.start) begin
        opa_d   = bus.op_a;
        cnt_d   = bus.op_b;
        div_d   = bus.op_b;
        res_d   = '0;
        rem_d   = bus.mode && bus.op_b != '0 ? bus.op_a : '0;
        ovf_d   = 1'b0;
        err_d   = bus.mode && bus.op_b == '0;
        state_d = bus.op_b == '0 ? DONE : bus.mode ? D_CMP : M_ADD;
      end
      M_ADD: begin
        alu_a_o = res_q;
        alu_b_o = opa_q;
        res_d   = alu_o_i;
        ovf_d   = ovf_q | alu_of_i;
        state_d = M_DEC;
      end
      M_DEC: begin
        alu_op_o = ALU_SUB;
        alu_a_o  = cnt_q;
        alu_b_o  = N'(1);
        cnt_d    = alu_o_i;
        state_d  = alu_o_i == '0 ? DONE : M_ADD;
      end
      D_CMP: begin
        alu_op_o = ALU_LT;
        alu_a_o  = rem_q;
        alu_b_o  = div_q;
        state_d  = alu_zero_i ? DONE : D_SUB;
      end
      D_SUB: begin
        alu_op_o = ALU_SUB;
        alu_a_o  = rem_q;
        alu_b_o  = div_q;
        rem_d    = alu_o_i;
        state_d  = D_INC;
      end
      D_INC: begin
        alu_a_o = res_q;
        alu_b_o = N'(1);
        res_d   = alu_o_i;
        state_d = D_CMP;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized and directed checks of the sequencer against an arithmetic model
module tb_alu_seq_ctrl;
  import alu_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] alu_a, alu_b, alu_o;
  logic [3:0] alu_op;
  logic alu_of, alu_zero;
  int checks = 0, errors = 0;
  alu_seq_ctrl_if #(.N(N)) ifc ();
  alu #(.N(N)) u_alu (.a_i(alu_a), .b_i(alu_b), .op_i(alu_op), .o_o(alu_o), .of_o(alu_of), .zero_o(alu_zero));
  alu_seq_ctrl #(.N(N)) dut (.clk(clk), .rst(rst), .bus(ifc.master), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_op_o(alu_op), .alu_o_i(alu_o), .alu_of_i(alu_of), .alu_zero_i(alu_zero));
  always #5 clk = ~clk;

  task automatic run_op(input logic m, input int a, input int b, input bit noise, input string tag);
    int er, erem, lat, n;
    logic eo, ee;
    logic [N-1:0] held;
    if (!m) begin
      er = (a * b) % 16; erem = 0; eo = (a * b) > 15; ee = 0; lat = 2 * b;
    end else if (b == 0) begin
      er = 0; erem = 0; eo = 0; ee = 1; lat = 0;
    end else begin
      er = a / b; erem = a % b; eo = 0; ee = 0; lat = 3 * (a / b) + 1;
    end
    @(negedge clk);
    ifc.start = 1'b1; ifc.mode = m; ifc.op_a = N'(a); ifc.op_b = N'(b);
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.op_a = N'($urandom); ifc.op_b = N'($urandom); ifc.mode = 1'($urandom);
    n = 0;
    while (!ifc.done && n < 200) begin
      checks++;
      if (ifc.busy !== 1'b1) begin errors++; $display("FAIL %s busy mid-op got %b want 1", tag, ifc.busy); end
      if (noise) begin ifc.start = 1'($urandom); ifc.op_a = N'($urandom); ifc.op_b = N'($urandom); end
      @(posedge clk); #1; n++;
    end
    ifc.start = 1'b0;
    checks++;
    if (n != lat) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, n, lat); end
    checks++;
    if (ifc.res !== N'(er)) begin errors++; $display("FAIL %s res got %0d want %0d", tag, ifc.res, er); end
    checks++;
    if (ifc.rem !== N'(erem)) begin errors++; $display("FAIL %s rem got %0d want %0d", tag, ifc.rem, erem); end
    checks++;
    if (ifc.ovf !== eo) begin errors++; $display("FAIL %s ovf got %b want %b", tag, ifc.ovf, eo); end
    checks++;
    if (ifc.err !== ee) begin errors++; $display("FAIL %s err got %b want %b", tag, ifc.err, ee); end
    held = ifc.res;
    @(posedge clk); #1;
    checks++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.res !== held)
      begin errors++; $display("FAIL %s after-done done=%b busy=%b res=%0d want 0 0 %0d", tag, ifc.done, ifc.busy, ifc.res, held); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ifc.busy, ifc.done, ifc.res, ifc.rem, ifc.ovf, ifc.err} !== '0)
      begin errors++; $display("FAIL reset outputs busy=%b done=%b res=%0d rem=%0d ovf=%b err=%b want all 0", ifc.busy, ifc.done, ifc.res, ifc.rem, ifc.ovf, ifc.err); end
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== ALU_ADD)
      begin errors++; $display("FAIL reset alu drive a=%0d b=%0d op=%0d want 0 0 0", alu_a, alu_b, alu_op); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(0, 2, 3, 0, "mul2x3");
    run_op(0, 5, 0, 0, "mul5x0");
    run_op(0, 5, 4, 0, "mul5x4");
    run_op(1, 7, 2, 0, "div7/2");
    run_op(1, 5, 0, 0, "div5/0");
    run_op(1, 3, 9, 0, "div3/9");
    run_op(0, 15, 15, 0, "mul15x15");
  endtask

  task automatic test_ignore_start();
    run_op(0, 3, 3, 1, "mul3x3-noise");
    run_op(0, 2, 5, 0, "fresh-after-noise");
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    ifc.start = 1'b1; ifc.mode = 1'b0; ifc.op_a = 4'd3; ifc.op_b = 4'd3;
    @(posedge clk); #1; ifc.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.res !== '0)
      begin errors++; $display("FAIL abort state busy=%b res=%0d want 0 0", ifc.busy, ifc.res); end
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (ifc.done) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort done pulses got %0d want 0", seen); end
    run_op(0, 2, 2, 0, "mul2x2-after-rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom), "rand");
  endtask

  task automatic test_back_to_back();
    run_op(1, 15, 1, 0, "b2b-div15/1");
    run_op(0, 1, 1, 0, "b2b-mul1x1");
    run_op(1, 0, 7, 0, "b2b-div0/7");
  endtask

  initial begin
    ifc.start = 1'b0; ifc.mode = 1'b0; ifc.op_a = '0; ifc.op_b = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
